// File: rtl/rvvi_retire_buffer.sv
// Purpose: compacts up to NRET retire lanes per cycle into an in-order single-instruction stream, checking order continuity.
// Latency: an entry written at a clock edge is presented at the head in the following cycle (first-word-fall-through).
// Backpressure: never stalls the core; a group that does not fit in the registered free space is dropped whole and counted.
module rvvi_retire_buffer #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int NRET  = 2,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NRET-1:0]        ret_valid,
    input  logic [NRET*64-1:0]     ret_order,
    input  logic [NRET*ILEN-1:0]   ret_insn,
    input  logic [NRET*XLEN-1:0]   ret_pc,
    input  logic [NRET-1:0]        ret_trap,
    input  logic [NRET-1:0]        ret_rd_wen,
    input  logic [NRET*5-1:0]      ret_rd_addr,
    input  logic [NRET*XLEN-1:0]   ret_rd_wdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [63:0]            out_order,
    output logic [ILEN-1:0]        out_insn,
    output logic [XLEN-1:0]        out_pc,
    output logic                   out_trap,
    output logic                   out_rd_wen,
    output logic [4:0]             out_rd_addr,
    output logic [XLEN-1:0]        out_rd_wdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   order_err,
    output logic [15:0]            dropped_cnt,
    input  logic                   clr_status
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [63:0]     order;
        logic [ILEN-1:0] insn;
        logic [XLEN-1:0] pc;
        logic            trap;
        logic            rd_wen;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
    } entry_t;

    typedef enum logic {SYNC, RUN} chk_state_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   n_lanes, free_slots;
    logic [AW-1:0]   lane_off [NRET];
    entry_t          lane_ent [NRET];
    logic            accept, drop, pop;
    entry_t          head;

    chk_state_t      state_q, state_d;
    logic [63:0]     exp_q, exp_d;
    logic            err_hit;
    logic [16:0]     drop_sum;
    logic [15:0]     drop_next;

    // Unpack lanes, count valid lanes and give each valid lane its slot offset.
    always_comb begin
        n_lanes = '0;
        for (int i = 0; i < NRET; i++) begin
            lane_off[i]          = n_lanes[AW-1:0];
            lane_ent[i].order    = ret_order[i*64 +: 64];
            lane_ent[i].insn     = ret_insn[i*ILEN +: ILEN];
            lane_ent[i].pc       = ret_pc[i*XLEN +: XLEN];
            lane_ent[i].trap     = ret_trap[i];
            lane_ent[i].rd_wen   = ret_rd_wen[i];
            lane_ent[i].rd_addr  = ret_rd_addr[i*5 +: 5];
            lane_ent[i].rd_wdata = ret_rd_wdata[i*XLEN +: XLEN];
            n_lanes              = n_lanes + CW'(ret_valid[i]);
        end
    end

    // Admission uses the registered occupancy only; a same-cycle pop earns no credit.
    assign free_slots = CW'(DEPTH) - count_q;
    assign accept     = (n_lanes != '0) && (n_lanes <= free_slots);
    assign drop       = (n_lanes > free_slots);
    assign out_valid  = (count_q != '0);
    assign pop        = out_valid && out_ready;

    // Write accepted lanes into consecutive slots in ascending lane order.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            for (int i = 0; i < NRET; i++) begin
                if (ret_valid[i]) begin
                    mem[wr_ptr + lane_off[i]] <= lane_ent[i];
                end
            end
        end
    end

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + n_lanes[AW-1:0];
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_q + (accept ? n_lanes : CW'(0)) - CW'(pop);
        end
    end

    // Order checker next state: walk accepted lanes in order, resyncing exp after every lane.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        err_hit = 1'b0;
        if (drop) begin
            state_d = SYNC;
        end else if (accept) begin
            for (int i = 0; i < NRET; i++) begin
                if (ret_valid[i]) begin
                    if (state_d == RUN && lane_ent[i].order != exp_d) err_hit = 1'b1;
                    state_d = RUN;
                    exp_d   = lane_ent[i].order + 64'd1;
                end
            end
        end
    end

    // Order checker state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SYNC;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
        end
    end

    // Drop counter: a clear in the same cycle as a drop restarts the count from this group.
    always_comb begin
        drop_sum  = {1'b0, (clr_status ? 16'h0 : dropped_cnt)} + 17'(n_lanes);
        drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Sticky status; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow    <= 1'b0;
            order_err   <= 1'b0;
            dropped_cnt <= '0;
        end else begin
            overflow  <= drop | (overflow & ~clr_status);
            order_err <= err_hit | (order_err & ~clr_status);
            if (drop)            dropped_cnt <= drop_next;
            else if (clr_status) dropped_cnt <= '0;
        end
    end

    // Head presentation, forced to zero when empty so no stale entry is visible.
    always_comb begin
        head         = mem[rd_ptr];
        out_order    = out_valid ? head.order    : '0;
        out_insn     = out_valid ? head.insn     : '0;
        out_pc       = out_valid ? head.pc       : '0;
        out_trap     = out_valid ? head.trap     : 1'b0;
        out_rd_wen   = out_valid ? head.rd_wen   : 1'b0;
        out_rd_addr  = out_valid ? head.rd_addr  : '0;
        out_rd_wdata = out_valid ? head.rd_wdata : '0;
    end

    assign count = count_q;

endmodule
